// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the bit positions of the EX/MEM control fields, the funct3 and opcode
// values the stage decodes, and the state type used by the access sequencer.
package mem_stage_pkg;

  // Control bit positions inside the 45-bit EX/MEM bundle
  localparam int unsigned CTRL_REGWRITE = 32;
  localparam int unsigned CTRL_MEMTOREG = 33;
  localparam int unsigned CTRL_MEMREAD  = 34;
  localparam int unsigned CTRL_MEMWRITE = 35;
  localparam int unsigned CTRL_BRANCH   = 36;

  localparam logic [2:0] FUNCT3_W   = 3'b010;
  localparam logic [2:0] FUNCT3_BEQ = 3'b000;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/memory_access_branch_resolve.sv
// Branch resolution for the MEM stage.
// Ports:
//   branch  - Branch control bit from EX/MEM
//   funct3  - instr[14:12] of the instruction in EX/MEM
//   zero    - EX ALU zero flag
//   pc_src  - 1 when a beq/bne is taken; other funct3 values never take
module branch_resolve
  import mem_stage_pkg::*;
(
  input  logic       branch,
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       pc_src
);

  always_comb begin
    pc_src = 1'b0;
    if (branch) begin
      unique case (funct3)
        FUNCT3_BEQ: pc_src = zero;
        FUNCT3_BNE: pc_src = !zero;
        default:    pc_src = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the 5-stage RISC-V pipeline.
// Issues lw/sw to an external data memory over a req/ack handshake, stalls
// upstream while an access is outstanding, resolves beq/bne and registers the
// MEM/WB bundle.
// Ports:
//   clk, rst                - pipeline clock, synchronous active-high reset
//   EXMEM, ALUresult,
//   WRITE_DATA, Zero,
//   PCBranch_EXMEM          - EX/MEM bundle
//   mem_req/we/addr/wdata   - registered memory request
//   mem_rdata, mem_ack      - memory response (ack is a one-cycle pulse)
//   stall                   - combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   PCSrc, PCBranch_target  - branch taken and target
//   MEMWB_*                 - registered write-back bundle
//   mem_err                 - sticky error (misaligned, illegal width, timeout)
module memory_access
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [44:0]       EXMEM,
  input  logic [31:0]       ALUresult,
  input  logic [31:0]       WRITE_DATA,
  input  logic              Zero,
  input  logic [7:0]        PCBranch_EXMEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              PCSrc,
  output logic [7:0]        PCBranch_target,
  output logic              MEMWB_RegWrite,
  output logic              MEMWB_MemtoReg,
  output logic [4:0]        MEMWB_rd,
  output logic [31:0]       MEMWB_ReadData,
  output logic [31:0]       MEMWB_ALUresult,
  output logic              mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        rdata_q;

  logic       reg_write, memto_reg, mem_read, mem_write, branch;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       mem_any, mem_op, illegal_op;

  assign reg_write = EXMEM[CTRL_REGWRITE];
  assign memto_reg = EXMEM[CTRL_MEMTOREG];
  assign mem_read  = EXMEM[CTRL_MEMREAD];
  assign mem_write = EXMEM[CTRL_MEMWRITE];
  assign branch    = EXMEM[CTRL_BRANCH];
  assign funct3    = EXMEM[14:12];
  assign rd        = EXMEM[11:7];

  assign mem_any    = mem_read | mem_write;
  assign mem_op     = mem_any && (state == IDLE) && (funct3 == FUNCT3_W);
  assign illegal_op = mem_any && (funct3 != FUNCT3_W);

  // DONE releases the stall so EX/MEM advances on the same edge MEM/WB loads
  assign stall = mem_op || (state == ACCESS);

  branch_resolve u_branch_resolve (
    .branch (branch),
    .funct3 (funct3),
    .zero   (Zero),
    .pc_src (PCSrc)
  );

  assign PCBranch_target = PCBranch_EXMEM;

  logic unused_bits;
  assign unused_bits = ^{EXMEM[44:37], EXMEM[31:15], EXMEM[6:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rdata_q         <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      MEMWB_RegWrite  <= 1'b0;
      MEMWB_MemtoReg  <= 1'b0;
      MEMWB_rd        <= '0;
      MEMWB_ReadData  <= '0;
      MEMWB_ALUresult <= '0;
      mem_err         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op || illegal_op) begin
            MEMWB_RegWrite  <= 1'b0;
            MEMWB_MemtoReg  <= 1'b0;
            MEMWB_rd        <= '0;
            MEMWB_ReadData  <= '0;
            MEMWB_ALUresult <= '0;
          end else begin
            MEMWB_RegWrite  <= reg_write;
            MEMWB_MemtoReg  <= memto_reg;
            MEMWB_rd        <= rd;
            MEMWB_ReadData  <= '0;
            MEMWB_ALUresult <= ALUresult;
          end
          if (illegal_op) mem_err <= 1'b1;
          if (mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_write;
            mem_addr  <= ALUresult[ADDR_W+1:2];
            mem_wdata <= WRITE_DATA;
            cnt       <= '0;
            rdata_q   <= '0;
            if (ALUresult[1:0] != 2'b00) mem_err <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          MEMWB_RegWrite  <= 1'b0;
          MEMWB_MemtoReg  <= 1'b0;
          MEMWB_rd        <= '0;
          MEMWB_ReadData  <= '0;
          MEMWB_ALUresult <= '0;
          // An ack on the final timeout cycle still completes normally
          if (mem_ack) begin
            rdata_q <= mem_we ? '0 : mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          MEMWB_RegWrite  <= reg_write;
          MEMWB_MemtoReg  <= memto_reg;
          MEMWB_rd        <= rd;
          MEMWB_ReadData  <= rdata_q;
          MEMWB_ALUresult <= ALUresult;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access. The bench plays the pipeline
// (holding EX/MEM while stalled) and the data memory (a word array), and
// predicts each instruction's outcome at transaction level.
module tb_memory_access;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic [44:0]       EXMEM;
  logic [31:0]       ALUresult;
  logic [31:0]       WRITE_DATA;
  logic              Zero;
  logic [7:0]        PCBranch_EXMEM;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              stall;
  logic              PCSrc;
  logic [7:0]        PCBranch_target;
  logic              MEMWB_RegWrite;
  logic              MEMWB_MemtoReg;
  logic [4:0]        MEMWB_rd;
  logic [31:0]       MEMWB_ReadData;
  logic [31:0]       MEMWB_ALUresult;
  logic              mem_err;

  memory_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .EXMEM           (EXMEM),
    .ALUresult       (ALUresult),
    .WRITE_DATA      (WRITE_DATA),
    .Zero            (Zero),
    .PCBranch_EXMEM  (PCBranch_EXMEM),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .stall           (stall),
    .PCSrc           (PCSrc),
    .PCBranch_target (PCBranch_target),
    .MEMWB_RegWrite  (MEMWB_RegWrite),
    .MEMWB_MemtoReg  (MEMWB_MemtoReg),
    .MEMWB_rd        (MEMWB_rd),
    .MEMWB_ReadData  (MEMWB_ReadData),
    .MEMWB_ALUresult (MEMWB_ALUresult),
    .mem_err         (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        exp_err;
  logic [31:0] mem_model [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    EXMEM = '0; ALUresult = '0; WRITE_DATA = '0; Zero = 1'b0; PCBranch_EXMEM = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(mem_req), 0);
    check({tag, "_rw"},    32'(MEMWB_RegWrite), 0);
    check({tag, "_mtr"},   32'(MEMWB_MemtoReg), 0);
    check({tag, "_rd"},    32'(MEMWB_rd), 0);
    check({tag, "_rdat"},  MEMWB_ReadData, 0);
    check({tag, "_alu"},   MEMWB_ALUresult, 0);
    check({tag, "_err"},   32'(mem_err), 0);
  endtask

  // Leaves the bench at posedge+1 with the DUT reset and idle.
  task automatic do_reset();
    rst = 1'b1;
    drive_nop();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_err = 1'b0;
    check_all_zero("reset");
    check("reset_we", 32'(mem_we), 0);
    check("reset_addr", 32'(mem_addr), 0);
    check("reset_wdata", mem_wdata, 0);
  endtask

  // One instruction through the MEM stage. Entered and left at posedge+1
  // with the stage idle. delay = ACCESS cycle on which memory acks.
  task automatic run_instr(input logic [4:0] ctrl, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [6:0] opc,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic zero, input logic [7:0] pcb,
                           input int unsigned delay);
    logic [16:0] hi;
    logic        is_mem, legal, timeout, exp_pcsrc;
    logic [7:0]  a;
    logic [31:0] exp_rdata;
    int unsigned n_access, stalls;
    hi = 17'($urandom());
    is_mem = ctrl[2] | ctrl[3];
    legal  = (f3 == 3'b010);
    exp_pcsrc = ctrl[4] && ((f3 == 3'b000 && zero) || (f3 == 3'b001 && !zero));
    EXMEM = {alu[7:0], ctrl, hi, f3, rd, opc};
    ALUresult = alu; WRITE_DATA = wd; Zero = zero; PCBranch_EXMEM = pcb;
    mem_ack = ($urandom_range(0, 3) == 0);
    mem_rdata = $urandom();
    @(negedge clk);
    check("stall_first", 32'(stall), 32'(is_mem && legal));
    check("pcsrc", 32'(PCSrc), 32'(exp_pcsrc));
    check("pc_target", 32'(PCBranch_target), 32'(pcb));
    check("req_idle", 32'(mem_req), 0);
    stalls = stall ? 1 : 0;
    if (!(is_mem && legal)) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (is_mem) begin
        exp_err = 1'b1;
        check("illegal_rw", 32'(MEMWB_RegWrite), 0);
      end else begin
        check("wb_rw", 32'(MEMWB_RegWrite), 32'(ctrl[0]));
        check("wb_mtr", 32'(MEMWB_MemtoReg), 32'(ctrl[1]));
        check("wb_rd", 32'(MEMWB_rd), 32'(rd));
        check("wb_rdata", MEMWB_ReadData, 0);
        check("wb_alu", MEMWB_ALUresult, alu);
      end
      check("err", 32'(mem_err), 32'(exp_err));
      return;
    end
    a = alu[9:2];
    if (alu[1:0] != 2'b00) exp_err = 1'b1;
    timeout  = (delay > TIMEOUT);
    n_access = timeout ? TIMEOUT : delay;
    for (int unsigned k = 1; k <= n_access; k++) begin
      @(posedge clk); #1;
      mem_ack   = (k == delay);
      mem_rdata = mem_ack ? mem_model[a] : $urandom();
      check("acc_req", 32'(mem_req), 1);
      check("acc_we", 32'(mem_we), 32'(ctrl[3]));
      check("acc_addr", 32'(mem_addr), 32'(a));
      check("acc_wdata", mem_wdata, wd);
      check("acc_bubble", 32'(MEMWB_RegWrite), 0);
      @(negedge clk);
      check("acc_stall", 32'(stall), 1);
      if (stall) stalls++;
    end
    @(posedge clk); #1;
    mem_ack   = ($urandom_range(0, 3) == 0);
    mem_rdata = $urandom();
    check("done_req", 32'(mem_req), 0);
    @(negedge clk);
    check("done_stall", 32'(stall), 0);
    if (timeout) begin
      exp_err = 1'b1;
      exp_rdata = '0;
    end else if (ctrl[3]) begin
      mem_model[a] = wd;
      exp_rdata = '0;
    end else begin
      exp_rdata = mem_model[a];
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stall_cycles", stalls, 1 + n_access);
    check("mwb_rw", 32'(MEMWB_RegWrite), 32'(ctrl[0]));
    check("mwb_mtr", 32'(MEMWB_MemtoReg), 32'(ctrl[1]));
    check("mwb_rd", 32'(MEMWB_rd), 32'(rd));
    check("mwb_rdata", MEMWB_ReadData, exp_rdata);
    check("mwb_alu", MEMWB_ALUresult, alu);
    check("err", 32'(mem_err), 32'(exp_err));
  endtask

  initial begin
    int unsigned kind, r, dly;
    logic [4:0]  ctrl, rd;
    logic [2:0]  f3;
    logic [31:0] alu, wd;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom();
    mem_model[4] = 32'hDEADBEEF;

    do_reset();

    // add x5 -> 0x2A
    run_instr(5'b00001, 3'b000, 5'd5, 7'b0110011, 32'h2A, 32'h0, 1'b0, 8'h00, 0);
    // lw x7, 0x10 with ack in first ACCESS cycle
    run_instr(5'b00111, 3'b010, 5'd7, 7'b0000011, 32'h10, 32'h0, 1'b0, 8'h00, 1);
    // sw to 0x20, ack on 4th ACCESS cycle
    run_instr(5'b01000, 3'b010, 5'd3, 7'b0100011, 32'h20, 32'h12345678, 1'b0, 8'h00, 4);
    // lw back the stored word
    run_instr(5'b00111, 3'b010, 5'd9, 7'b0000011, 32'h20, 32'h0, 1'b0, 8'h00, 2);
    // ack exactly on the timeout cycle wins
    run_instr(5'b00111, 3'b010, 5'd10, 7'b0000011, 32'h30, 32'h0, 1'b0, 8'h00, TIMEOUT);
    // beq taken, bne not taken
    run_instr(5'b10000, 3'b000, 5'd0, 7'b1100011, 32'h0, 32'h0, 1'b1, 8'h3C, 0);
    run_instr(5'b10000, 3'b001, 5'd0, 7'b1100011, 32'h0, 32'h0, 1'b1, 8'h3C, 0);
    // lw with no ack at all -> timeout
    run_instr(5'b00111, 3'b010, 5'd11, 7'b0000011, 32'h44, 32'h0, 1'b0, 8'h00, 1000);

    // reset in 2nd ACCESS cycle together with an ack, then a late ack
    EXMEM = {8'h40, 5'b00111, 17'h0, 3'b010, 5'd12, 7'b0000011};
    ALUresult = 32'h40; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_pre_req", 32'(mem_req), 1);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_nop();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    exp_err = 1'b0;
    check_all_zero("rst_mid");
    @(negedge clk);
    check("rst_mid_stall", 32'(stall), 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check_all_zero("rst_late_ack");

    do_reset();
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      rd   = 5'($urandom());
      alu  = $urandom();
      wd   = $urandom();
      f3   = 3'b010;
      if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
      r = $urandom_range(0, 19);
      dly = (r == 0) ? TIMEOUT : (r == 1) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 4)
                                           : $urandom_range(1, 6);
      case (kind)
        0, 1, 2: begin
          ctrl = {3'b000, 2'($urandom())};
          f3 = 3'($urandom());
          run_instr(ctrl, f3, rd, 7'b0110011, alu, wd, 1'($urandom()), 8'($urandom()), 0);
        end
        3, 4: run_instr(5'b00111, f3, rd, 7'b0000011, alu, wd, 1'b0, 8'h00, dly);
        5, 6: run_instr(5'b01000, f3, rd, 7'b0100011, alu, wd, 1'b0, 8'h00, dly);
        7, 8: begin
          f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : 3'($urandom_range(0, 1));
          run_instr(5'b10000, f3, rd, 7'b1100011, alu, wd, 1'($urandom()), 8'($urandom()), 0);
        end
        default: begin
          f3 = 3'($urandom_range(3, 7));
          ctrl = ($urandom_range(0, 1) == 0) ? 5'b00111 : 5'b01000;
          run_instr(ctrl, f3, rd, 7'b0000011, alu, wd, 1'b0, 8'h00, 1);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
